// File: rtl/run_controller_if.sv
// run_controller_if -- bus between the run controller and its host/bench.
//   master : host side (drives start/stop/step controls and port_in)
//   slave  : run_controller side (drives init_mem/dp_reset/dp_run/status)
// Optional macro RUN_CTRL_BREAKPOINT_EN adds pc_in, bp_addr, bp_enable, bp_hit.
interface run_controller_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);
  logic                  start;
  logic                  stop;
  logic                  step_mode;
  logic                  step;
  logic [DATA_WIDTH-1:0] port_in;
  logic                  port_in_load;
  logic [DATA_WIDTH-1:0] iport_out;
  logic                  init_mem;
  logic                  dp_reset;
  logic                  dp_run;
  logic                  done;
  logic                  timeout;
  logic [CNT_WIDTH-1:0]  cycle_count;
  logic [2:0]            state;
`ifdef RUN_CTRL_BREAKPOINT_EN
  logic [DATA_WIDTH-1:0] pc_in;
  logic [DATA_WIDTH-1:0] bp_addr;
  logic                  bp_enable;
  logic                  bp_hit;
`endif

  modport master (
`ifdef RUN_CTRL_BREAKPOINT_EN
    output pc_in, bp_addr, bp_enable,
    input  bp_hit,
`endif
    output start, stop, step_mode, step, port_in, port_in_load,
    input  iport_out, init_mem, dp_reset, dp_run, done, timeout, cycle_count, state
  );

  modport slave (
`ifdef RUN_CTRL_BREAKPOINT_EN
    input  pc_in, bp_addr, bp_enable,
    output bp_hit,
`endif
    input  start, stop, step_mode, step, port_in, port_in_load,
    output iport_out, init_mem, dp_reset, dp_run, done, timeout, cycle_count, state
  );
endinterface

// File: rtl/run_controller.sv
// run_controller -- run-control sequencer in front of the DataPath.
// Issues the memory-init strobe, holds the datapath in reset for a window,
// then gates execution through dp_run in free-run, single-step or
// cycle-limited mode. Also registers the IPortInput value.
// Ports:
//   i_clock  : rising-edge clock
//   i_reset  : synchronous active-high reset (back to IDLE)
//   bus      : run_controller_if.slave (controls in, sequencing/status out)
// Optional macro RUN_CTRL_BREAKPOINT_EN: PC breakpoint that drops RUN into STEP.
module run_controller #(
  parameter int DATA_WIDTH   = 32,
  parameter int INIT_CYCLES  = 1,
  parameter int RESET_CYCLES = 2,
  parameter int CNT_WIDTH    = 32,
  parameter int MAX_CYCLES   = 0
) (
  input logic             i_clock,
  input logic             i_reset,
  run_controller_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_INIT = 3'd1, S_RST = 3'd2,
    S_RUN  = 3'd3, S_STEP = 3'd4, S_HALT = 3'd5
  } state_t;

  localparam int SEQ_MAX = (INIT_CYCLES > RESET_CYCLES) ? INIT_CYCLES : RESET_CYCLES;
  localparam int SEQ_W   = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;
  localparam logic [SEQ_W-1:0]     INIT_LD = SEQ_W'(INIT_CYCLES - 1);
  localparam logic [SEQ_W-1:0]     RST_LD  = SEQ_W'(RESET_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LIMIT   = CNT_WIDTH'(MAX_CYCLES);

  state_t                r_state;
  logic [SEQ_W-1:0]      r_seq;
  logic [CNT_WIDTH-1:0]  r_cycle_count;
  logic [DATA_WIDTH-1:0] r_iport;
  logic                  r_init_mem, r_dp_reset, r_dp_run, r_done, r_timeout;

  logic [CNT_WIDTH-1:0]  w_cnt_inc;
  logic                  w_limit, w_bp, w_hold, w_grant;

  // Saturating increment; the limit is judged on the post-increment value.
  assign w_cnt_inc = (r_cycle_count == '1) ? r_cycle_count : r_cycle_count + CNT_WIDTH'(1);
  assign w_limit   = (MAX_CYCLES != 0) && (w_cnt_inc == LIMIT);

`ifdef RUN_CTRL_BREAKPOINT_EN
  logic r_bp_hit, r_bp_hold;
  assign w_bp   = bus.bp_enable && (bus.pc_in == bus.bp_addr);
  // While parked on a breakpoint, step_mode=0 must not resume until the PC moves.
  assign w_hold = r_bp_hold && w_bp;
  assign bus.bp_hit = r_bp_hit;
`else
  assign w_bp   = 1'b0;
  assign w_hold = 1'b0;
`endif

  // A step in the same cycle as step_mode falling is dropped unless parked.
  assign w_grant = bus.step && (bus.step_mode || w_hold);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_seq         <= '0;
      r_cycle_count <= '0;
      r_iport       <= '0;
      r_init_mem    <= 1'b0;
      r_dp_reset    <= 1'b1;
      r_dp_run      <= 1'b0;
      r_done        <= 1'b0;
      r_timeout     <= 1'b0;
`ifdef RUN_CTRL_BREAKPOINT_EN
      r_bp_hit      <= 1'b0;
      r_bp_hold     <= 1'b0;
`endif
    end else begin
      if (bus.port_in_load) r_iport <= bus.port_in;
`ifdef RUN_CTRL_BREAKPOINT_EN
      r_bp_hit <= 1'b0;
      if (!w_bp) r_bp_hold <= 1'b0;
`endif
      case (r_state)
        S_IDLE, S_HALT: begin
          if (bus.start) begin
            r_state       <= S_INIT;
            r_seq         <= INIT_LD;
            r_cycle_count <= '0;
            r_init_mem    <= 1'b1;
            r_dp_reset    <= 1'b1;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
`ifdef RUN_CTRL_BREAKPOINT_EN
            r_bp_hold     <= 1'b0;
`endif
          end
        end
        S_INIT: begin
          if (r_seq == '0) begin
            r_state    <= S_RST;
            r_seq      <= RST_LD;
            r_init_mem <= 1'b0;
          end else begin
            r_seq <= r_seq - SEQ_W'(1);
          end
        end
        S_RST: begin
          if (r_seq == '0) begin
            r_dp_reset <= 1'b0;
            r_state    <= bus.step_mode ? S_STEP : S_RUN;
            r_dp_run   <= !bus.step_mode;
          end else begin
            r_seq <= r_seq - SEQ_W'(1);
          end
        end
        S_RUN: begin
          r_cycle_count <= w_cnt_inc;
          if (bus.stop || w_limit) begin
            r_state   <= S_HALT;
            r_dp_run  <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= !bus.stop;  // stop wins over the limit
          end else if (w_bp || bus.step_mode) begin
            r_state  <= S_STEP;
            r_dp_run <= 1'b0;
`ifdef RUN_CTRL_BREAKPOINT_EN
            if (w_bp) begin
              r_bp_hit  <= 1'b1;
              r_bp_hold <= 1'b1;
            end
`endif
          end
        end
        S_STEP: begin
          if (r_dp_run) begin
            // The granted cycle: counted, and may halt.
            r_cycle_count <= w_cnt_inc;
            if (bus.stop || w_limit) begin
              r_state   <= S_HALT;
              r_dp_run  <= 1'b0;
              r_done    <= 1'b1;
              r_timeout <= !bus.stop;
            end else if (!bus.step_mode && !w_hold) begin
              r_state  <= S_RUN;
              r_dp_run <= 1'b1;
            end else begin
              r_dp_run <= w_grant;
            end
          end else if (w_grant) begin
            r_dp_run <= 1'b1;
          end else if (!bus.step_mode && !w_hold) begin
            r_state  <= S_RUN;
            r_dp_run <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_init_mem <= 1'b0;
          r_dp_reset <= 1'b1;
          r_dp_run   <= 1'b0;
          r_done     <= 1'b0;
          r_timeout  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.iport_out   = r_iport;
  assign bus.init_mem    = r_init_mem;
  assign bus.dp_reset    = r_dp_reset;
  assign bus.dp_run      = r_dp_run;
  assign bus.done        = r_done;
  assign bus.timeout     = r_timeout;
  assign bus.cycle_count = r_cycle_count;
  assign bus.state       = r_state;
endmodule

// File: tb/tb_run_controller.sv
module tb_run_controller;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2;
  int   n_tests = 0;
  int   n_fail  = 0;

  run_controller_if #(.DATA_WIDTH(32), .CNT_WIDTH(32)) bus0 ();
  run_controller_if #(.DATA_WIDTH(32), .CNT_WIDTH(32)) bus1 ();
  run_controller_if #(.DATA_WIDTH(32), .CNT_WIDTH(3))  bus2 ();

  run_controller #(.DATA_WIDTH(32), .CNT_WIDTH(32), .MAX_CYCLES(0))
    u_dut (.i_clock(clk), .i_reset(rst0), .bus(bus0));
  run_controller #(.DATA_WIDTH(32), .CNT_WIDTH(32), .MAX_CYCLES(5))
    u_lim (.i_clock(clk), .i_reset(rst1), .bus(bus1));
  run_controller #(.DATA_WIDTH(32), .CNT_WIDTH(3), .MAX_CYCLES(0))
    u_sat (.i_clock(clk), .i_reset(rst2), .bus(bus2));

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    bus0.start = 0; bus0.stop = 0; bus0.step_mode = 0; bus0.step = 0;
    bus0.port_in = '0; bus0.port_in_load = 0;
    bus1.start = 0; bus1.stop = 0; bus1.step_mode = 0; bus1.step = 0;
    bus1.port_in = '0; bus1.port_in_load = 0;
    bus2.start = 0; bus2.stop = 0; bus2.step_mode = 0; bus2.step = 0;
    bus2.port_in = '0; bus2.port_in_load = 0;
`ifdef RUN_CTRL_BREAKPOINT_EN
    bus0.pc_in = '0; bus0.bp_addr = '0; bus0.bp_enable = 0;
    bus1.pc_in = '0; bus1.bp_addr = '0; bus1.bp_enable = 0;
    bus2.pc_in = '0; bus2.bp_addr = '0; bus2.bp_enable = 0;
`endif
    tick(2);
    chk("rst_state",    bus0.state, 0);
    chk("rst_init_mem", bus0.init_mem, 0);
    chk("rst_dp_reset", bus0.dp_reset, 1);
    chk("rst_dp_run",   bus0.dp_run, 0);
    chk("rst_done",     bus0.done, 0);
    chk("rst_timeout",  bus0.timeout, 0);
    chk("rst_count",    bus0.cycle_count, 0);
    chk("rst_iport",    bus0.iport_out, 0);
    rst0 = 1'b0;

    // step pulse in IDLE does nothing
    bus0.step = 1; tick(); bus0.step = 0;
    chk("idle_step_state", bus0.state, 0);
    chk("idle_step_run",   bus0.dp_run, 0);

    // sequencing: INIT 1 cycle, RST 2 cycles, RUN on the 4th
    bus0.start = 1; tick(); bus0.start = 0;
    chk("seq1_state", bus0.state, 1);
    chk("seq1_init",  bus0.init_mem, 1);
    chk("seq1_rst",   bus0.dp_reset, 1);
    tick();
    chk("seq2_state", bus0.state, 2);
    chk("seq2_init",  bus0.init_mem, 0);
    chk("seq2_rst",   bus0.dp_reset, 1);
    tick();
    chk("seq3_state", bus0.state, 2);
    chk("seq3_run",   bus0.dp_run, 0);
    tick();
    chk("seq4_state", bus0.state, 3);
    chk("seq4_run",   bus0.dp_run, 1);
    chk("seq4_rst",   bus0.dp_reset, 0);
    chk("seq4_count", bus0.cycle_count, 0);

    // free-run, start ignored in RUN, halt on stop
    tick(5);
    bus0.start = 1; tick(); bus0.start = 0;
    chk("run_start_ign", bus0.state, 3);
    chk("run_count6",    bus0.cycle_count, 6);
    tick(4);
    chk("run_count10",   bus0.cycle_count, 10);
    bus0.stop = 1; tick(); bus0.stop = 0;
    chk("halt_done",  bus0.done, 1);
    chk("halt_state", bus0.state, 5);
    chk("halt_count", bus0.cycle_count, 11);
    chk("halt_run",   bus0.dp_run, 0);
    chk("halt_to",    bus0.timeout, 0);
    tick();
    chk("halt_run2",  bus0.dp_run, 0);
    chk("halt_cnt2",  bus0.cycle_count, 11);

    // restart into single-step
    bus0.start = 1; tick(); bus0.start = 0;
    chk("restart_state", bus0.state, 1);
    chk("restart_count", bus0.cycle_count, 0);
    chk("restart_done",  bus0.done, 0);
    bus0.step_mode = 1;
    tick(3);
    chk("step_enter", bus0.state, 4);
    chk("step_idle",  bus0.dp_run, 0);
    for (int i = 0; i < 3; i++) begin
      bus0.step = 1; tick(); bus0.step = 0;
      chk("step_pulse_on", bus0.dp_run, 1);
      tick();
      chk("step_pulse_off", bus0.dp_run, 0);
      tick(2);
      chk("step_quiet", bus0.dp_run, 0);
    end
    chk("step_count", bus0.cycle_count, 3);

    // step together with step_mode falling is dropped -> RUN
    bus0.step_mode = 0; bus0.step = 1; tick(); bus0.step = 0;
    chk("step_drop_state", bus0.state, 3);
    chk("step_drop_run",   bus0.dp_run, 1);
    tick(3);
    bus0.port_in = 32'hDEADBEEF; bus0.port_in_load = 1; tick(); bus0.port_in_load = 0;
    chk("iport_load", bus0.iport_out, 32'hDEADBEEF);
    chk("mid_count7", bus0.cycle_count, 7);

    // mid-run reset
    rst0 = 1; tick(); rst0 = 0;
    chk("mrst_state", bus0.state, 0);
    chk("mrst_count", bus0.cycle_count, 0);
    chk("mrst_dprst", bus0.dp_reset, 1);
    chk("mrst_run",   bus0.dp_run, 0);
    chk("mrst_iport", bus0.iport_out, 0);

`ifdef RUN_CTRL_BREAKPOINT_EN
    bus0.bp_enable = 1; bus0.bp_addr = 32'h10; bus0.pc_in = 32'h0;
    bus0.start = 1; tick(); bus0.start = 0;
    tick(3);
    chk("bp_run", bus0.state, 3);
    tick(); bus0.pc_in = 32'h4;
    tick(); bus0.pc_in = 32'h8;
    tick(); bus0.pc_in = 32'hC;
    tick(); bus0.pc_in = 32'h10;
    chk("bp_pre_hit", bus0.bp_hit, 0);
    tick();
    chk("bp_hit",       bus0.bp_hit, 1);
    chk("bp_state",     bus0.state, 4);
    chk("bp_run_off",   bus0.dp_run, 0);
    tick();
    chk("bp_hit_pulse", bus0.bp_hit, 0);
    chk("bp_parked",    bus0.state, 4);
    chk("bp_park_run",  bus0.dp_run, 0);
    bus0.step = 1; tick(); bus0.step = 0;
    chk("bp_step_run",  bus0.dp_run, 1);
    bus0.pc_in = 32'h14;
    tick();
    chk("bp_resume",    bus0.state, 3);
    chk("bp_resume_run", bus0.dp_run, 1);
`endif

    // cycle limit
    rst1 = 0;
    bus1.start = 1; tick(); bus1.start = 0;
    tick(3);
    tick(4);
    chk("lim_count4", bus1.cycle_count, 4);
    chk("lim_state4", bus1.state, 3);
    tick();
    chk("lim_state",   bus1.state, 5);
    chk("lim_timeout", bus1.timeout, 1);
    chk("lim_count",   bus1.cycle_count, 5);
    chk("lim_done",    bus1.done, 1);
    bus1.start = 1; tick(); bus1.start = 0;
    chk("lim_to_clr", bus1.timeout, 0);
    tick(3);
    tick(4);
    bus1.stop = 1; tick(); bus1.stop = 0;
    chk("lim_stop_state", bus1.state, 5);
    chk("lim_stop_to",    bus1.timeout, 0);
    chk("lim_stop_count", bus1.cycle_count, 5);

    // counter saturation with a 3-bit counter
    rst2 = 0;
    bus2.start = 1; tick(); bus2.start = 0;
    tick(3);
    tick(9);
    chk("sat_count", bus2.cycle_count, 7);
    chk("sat_state", bus2.state, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
